// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch stage: FSM state encoding, address width,
// and default reset PC / memory depth.
package fetch_pkg;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 32;

  localparam logic [ADDR_W-1:0] DEF_RESET_PC  = 32'd0;
  localparam int unsigned       DEF_MEM_DEPTH = 65536;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_REPLAY = 2'd1,
    ST_HALTED = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

endpackage

// File: rtl/fetch_perf_counters.sv
// Saturating cycle and retire counters for the fetch stage. Only built when
// FETCH_PERF_CNT_EN is defined.
module fetch_perf_counters
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cycle_en,
  input  logic             retire_en,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] retire_q, retire_d;

  // Both counters stick at all-ones instead of wrapping.
  always_comb begin
    cycle_d  = cycle_q;
    retire_d = retire_q;
    if (cycle_en && (cycle_q != '1)) cycle_d = cycle_q + 1'b1;
    if (retire_en && (retire_q != '1)) retire_d = retire_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q  <= '0;
      retire_q <= '0;
    end else begin
      cycle_q  <= cycle_d;
      retire_q <= retire_d;
    end
  end

  assign cycle_cnt  = cycle_q;
  assign retire_cnt = retire_q;

endmodule

// File: rtl/fetch_unit.sv
// Program counter and fetch control ahead of a 1-cycle registered instruction memory.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = DEF_RESET_PC,
  parameter int unsigned       MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              halt_req,
  input  logic              resume,
  output logic [ADDR_W-1:0] addr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_of_instr,
  output logic              halted,
  output logic              fault,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [ADDR_W:0]   addr_inc;
  logic              inc_ok;
  logic              tgt_ok;

  // One extra bit so that incrementing 0xFFFFFFFF cannot wrap into a legal address.
  assign addr_inc = {1'b0, addr_q} + 1'b1;
  assign inc_ok   = addr_inc < DEPTH;
  assign tgt_ok   = {1'b0, redirect_target} < DEPTH;

  // While in REPLAY, addr_q itself holds the replay address R, so no separate copy is kept.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pc_d    = addr_q;
    valid_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALTED;
        end else if (redirect_valid) begin
          if (tgt_ok) addr_d = redirect_target;
          else        state_d = ST_FAULT;
        end else if (stall && valid_q) begin
          addr_d  = pc_q;
          state_d = ST_REPLAY;
        end else if (inc_ok) begin
          addr_d  = addr_inc[ADDR_W-1:0];
          valid_d = 1'b1;
        end else begin
          state_d = ST_FAULT;
        end
      end
      ST_REPLAY, ST_HALTED: begin
        if ((state_q == ST_REPLAY) ? !stall : resume) begin
          if (inc_ok) begin
            addr_d  = addr_inc[ADDR_W-1:0];
            valid_d = 1'b1;
            state_d = ST_RUN;
          end else begin
            state_d = ST_FAULT;
          end
        end
      end
      default: state_d = ST_FAULT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      addr_q  <= RESET_PC;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign addr        = addr_q;
  assign instr_valid = valid_q;
  assign pc_of_instr = pc_q;
  assign halted      = (state_q == ST_HALTED);
  assign fault       = (state_q == ST_FAULT);

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_counters u_perf (
    .clk        (clk),
    .rst        (rst),
    .cycle_en   (state_q != ST_FAULT),
    .retire_en  (valid_q && !stall),
    .cycle_cnt  (cycle_cnt),
    .retire_cnt (retire_cnt)
  );
`else
  assign cycle_cnt  = '0;
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a vector table applied cycle by cycle against a
// default-depth instance and a 16-word instance, plus a counter sequence.
module tb_fetch_unit;
  import fetch_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, redirect_valid = 1'b0, halt_req = 1'b0, resume = 1'b0;
  logic [31:0] redirect_target = '0;

  always #5 clk = ~clk;

  logic [31:0] m_addr, m_pc, m_cyc, m_ret;
  logic        m_valid, m_halted, m_fault;
  logic [31:0] s_addr, s_pc, s_cyc, s_ret;
  logic        s_valid, s_halted, s_fault;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .halt_req(halt_req), .resume(resume),
    .addr(m_addr), .instr_valid(m_valid), .pc_of_instr(m_pc), .halted(m_halted),
    .fault(m_fault), .cycle_cnt(m_cyc), .retire_cnt(m_ret)
  );

  fetch_unit #(.MEM_DEPTH(16)) dut_small (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .halt_req(halt_req), .resume(resume),
    .addr(s_addr), .instr_valid(s_valid), .pc_of_instr(s_pc), .halted(s_halted),
    .fault(s_fault), .cycle_cnt(s_cyc), .retire_cnt(s_ret)
  );

  // ---------------- vectors and scoreboard ----------------
  typedef struct {
    logic        do_rst;
    logic        sel;
    logic        st, rd;
    logic [31:0] tgt;
    logic        hr, rs;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_halted, e_fault;
  } vec_t;

  vec_t        vecs[$];
  logic [66:0] exp_q[$];
  logic [63:0] cnt_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;

  function automatic vec_t mk(logic r, logic sel, logic st, logic rd, logic [31:0] tgt,
                              logic hr, logic rs, logic [31:0] ea, logic ev,
                              logic [31:0] ep, logic eh, logic ef);
    vec_t v;
    v.do_rst = r; v.sel = sel; v.st = st; v.rd = rd; v.tgt = tgt; v.hr = hr; v.rs = rs;
    v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_halted = eh; v.e_fault = ef;
    return v;
  endfunction

  task automatic check(input int idx, input logic sel);
    logic [66:0] exp, act;
    exp = exp_q.pop_front();
    act = sel ? {s_addr, s_valid, s_pc, s_halted, s_fault}
              : {m_addr, m_valid, m_pc, m_halted, m_fault};
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec%0d dut%0d: got addr=%h v=%b pc=%h h=%b f=%b, want addr=%h v=%b pc=%h h=%b f=%b",
               idx, sel, act[66:35], act[34], act[33:2], act[1], act[0],
               exp[66:35], exp[34], exp[33:2], exp[1], exp[0]);
    end
  endtask

  task automatic check_cnt(input string name);
    logic [63:0] exp;
    exp = cnt_q.pop_front();
    n_cmp++;
    if ({m_cyc, m_ret} !== exp) begin
      n_fail++;
      $display("FAIL %s: got cycle=%0d retire=%0d, want cycle=%0d retire=%0d",
               name, m_cyc, m_ret, exp[63:32], exp[31:0]);
    end
  endtask

  // Bench is always positioned just after a negedge when applying a vector.
  task automatic apply(input int idx, input vec_t v);
    stall = v.st; redirect_valid = v.rd; redirect_target = v.tgt;
    halt_req = v.hr; resume = v.rs;
    exp_q.push_back({v.e_addr, v.e_valid, v.e_pc, v.e_halted, v.e_fault});
    if (v.do_rst) begin
      rst = 1'b1;
      #1 check(idx, v.sel);
      @(negedge clk);
      rst = 1'b0;
    end else begin
      @(posedge clk);
      #1 check(idx, v.sel);
      @(negedge clk);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    // Sequential fetch, redirect, stall replay, halt/resume on the default instance.
    vecs.push_back(mk(1,0, 0,0,0,0,0, 32'h0,0,32'h0,0,0));
    for (int k = 1; k <= 5; k++) vecs.push_back(mk(0,0, 0,0,0,0,0, k,1,k-1,0,0));
    vecs.push_back(mk(0,0, 0,1,32'h40,0,0, 32'h40,0,32'h5,0,0));
    vecs.push_back(mk(0,0, 0,0,0,0,0, 32'h41,1,32'h40,0,0));
    vecs.push_back(mk(0,0, 0,0,0,0,0, 32'h42,1,32'h41,0,0));
    vecs.push_back(mk(0,0, 1,1,32'h6,0,0, 32'h6,0,32'h42,0,0));   // redirect beats stall
    vecs.push_back(mk(0,0, 1,0,0,0,0, 32'h7,1,32'h6,0,0));        // stall ignored in bubble
    vecs.push_back(mk(0,0, 0,0,0,0,0, 32'h8,1,32'h7,0,0));
    vecs.push_back(mk(0,0, 1,0,0,0,0, 32'h7,0,32'h8,0,0));
    vecs.push_back(mk(0,0, 1,0,0,0,0, 32'h7,0,32'h7,0,0));
    vecs.push_back(mk(0,0, 1,0,0,0,0, 32'h7,0,32'h7,0,0));
    vecs.push_back(mk(0,0, 0,0,0,0,0, 32'h8,1,32'h7,0,0));
    vecs.push_back(mk(0,0, 0,0,0,0,0, 32'h9,1,32'h8,0,0));
    vecs.push_back(mk(0,0, 0,1,32'h10,0,0, 32'h10,0,32'h9,0,0));
    vecs.push_back(mk(0,0, 0,0,0,1,0, 32'h10,0,32'h10,1,0));
    vecs.push_back(mk(0,0, 1,1,32'h30,0,0, 32'h10,0,32'h10,1,0));
    vecs.push_back(mk(0,0, 1,1,32'h30,1,0, 32'h10,0,32'h10,1,0));
    vecs.push_back(mk(0,0, 0,0,0,0,0, 32'h10,0,32'h10,1,0));
    vecs.push_back(mk(0,0, 0,0,0,1,0, 32'h10,0,32'h10,1,0));
    vecs.push_back(mk(0,0, 0,0,0,1,1, 32'h11,1,32'h10,0,0));      // resume beats halt_req
    vecs.push_back(mk(0,0, 0,0,0,0,0, 32'h12,1,32'h11,0,0));
    vecs.push_back(mk(0,0, 0,1,32'h30,1,0, 32'h12,0,32'h12,1,0)); // halt beats redirect
    vecs.push_back(mk(0,0, 0,0,0,0,1, 32'h13,1,32'h12,0,0));
    vecs.push_back(mk(0,0, 0,0,0,0,0, 32'h14,1,32'h13,0,0));
    vecs.push_back(mk(1,0, 0,0,0,0,0, 32'h0,0,32'h0,0,0));        // async reset mid-run
    vecs.push_back(mk(0,0, 0,0,0,0,0, 32'h1,1,32'h0,0,0));
    // 16-word instance: run off the end.
    vecs.push_back(mk(1,1, 0,0,0,0,0, 32'h0,0,32'h0,0,0));
    for (int k = 1; k <= 15; k++) vecs.push_back(mk(0,1, 0,0,0,0,0, k,1,k-1,0,0));
    vecs.push_back(mk(0,1, 0,0,0,0,0, 32'hF,0,32'hF,0,1));
    vecs.push_back(mk(0,1, 0,1,32'h2,0,1, 32'hF,0,32'hF,0,1));
    // 16-word instance: out-of-range redirect, then legal edge redirect.
    vecs.push_back(mk(1,1, 0,0,0,0,0, 32'h0,0,32'h0,0,0));
    vecs.push_back(mk(0,1, 0,1,32'h20,0,0, 32'h0,0,32'h0,0,1));
    vecs.push_back(mk(0,1, 0,0,0,0,1, 32'h0,0,32'h0,0,1));
    vecs.push_back(mk(1,1, 0,0,0,0,0, 32'h0,0,32'h0,0,0));
    vecs.push_back(mk(0,1, 0,1,32'hF,0,0, 32'hF,0,32'h0,0,0));
    vecs.push_back(mk(0,1, 0,0,0,0,0, 32'hF,0,32'hF,0,1));
    vecs.push_back(mk(0,1, 0,0,0,1,0, 32'hF,0,32'hF,0,1));
    vecs.push_back(mk(1,1, 0,0,0,0,0, 32'h0,0,32'h0,0,0));
    vecs.push_back(mk(0,1, 0,0,0,0,0, 32'h1,1,32'h0,0,0));

    @(negedge clk);
    foreach (vecs[i]) apply(i, vecs[i]);

    // Counters: 10 cycles after reset, stall on cycles 3 and 4.
    stall = 0; redirect_valid = 0; halt_req = 0; resume = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      stall = (e == 3) || (e == 4);
      @(posedge clk);
      @(negedge clk);
    end
    stall = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    cnt_q.push_back({32'd10, 32'd6});
`else
    cnt_q.push_back({32'd0, 32'd0});
`endif
    check_cnt("cnt_after_10");
    rst = 1'b1;
    cnt_q.push_back({32'd0, 32'd0});
    #1 check_cnt("cnt_after_rst");
    @(negedge clk);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
